uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit sequencer that drives the existing bit serializer. It accepts a byte through a start/busy/done handshake and generates the serializer's `out_sel`, `counter_i`, `end_bit_time` and `parity` controls to emit one frame: start bit, 8 data bits LSB first, optional parity bit, and stop bit. It owns the baud-rate timing and sits between the CPU-side UART register interface and the serializer.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200). Legal range is 2 or more.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tx_start` input 1: request to send `tx_data`. Sampled only while `busy`=0.
- `tx_data` input 8: byte to send, captured on the accept edge.
- `par_odd` input 1: 1 selects odd parity, 0 selects even. Ignored when parity is compiled out.
- `A` output 8: latched byte, driven to the serializer.
- `out_sel` output 3: field select. 000 idle(1), 001 start(0), 010 data, 011 parity, 100 stop(1).
- `counter_i` output 3: data bit index, 0 to 7.
- `end_bit_time` output 1: one-cycle pulse marking a bit boundary. The serializer latches on it.
- `parity` output 1: parity of `A`.
- `busy` output 1: high from reset until the line is idle, and from accept until frame end.
- `tx_done` output 1: one-cycle pulse at frame end.

## Operation
- All outputs are registered.
- Reset values:
  - `A`=0, `out_sel`=000, `counter_i`=0, `end_bit_time`=0, `parity`=0, `tx_done`=0.
  - `busy`=1.
  - State is INIT.
- FSM states: INIT, IDLE, START, DATA, PARITY, STOP.
- INIT:
  - Lasts one cycle after reset release.
  - Issues `end_bit_time`=1 with `out_sel`=000, which drives the line high (the serializer resets to 0).
  - Moves to IDLE.
- IDLE:
  - `busy`=0 and `out_sel`=000.
  - `tx_start`=1 on an edge where `busy`=0 is an accept.
  - On accept: `A`←`tx_data`, `parity`←^`tx_data` (XOR reduction), or its inverse if `par_odd`=1. Next state is START.
- Bit boundaries:
  - Each state change out of START, DATA, PARITY or STOP coincides with an `end_bit_time` pulse.
  - In that pulse cycle, `out_sel` and `counter_i` already hold the field of the bit now starting.
- START: `out_sel`=001. After one bit period, go to DATA with `counter_i`=0.
- DATA:
  - `out_sel`=010.
  - At each boundary, `counter_i` increments.
  - At the boundary after bit 7, go to PARITY, or to STOP if parity is compiled out. `counter_i` returns to 0.
- PARITY: `out_sel`=011, one bit period, then STOP.
- STOP: `out_sel`=100, one bit period.
- End of STOP:
  - Pulse `end_bit_time` with `out_sel`=000.
  - Enter IDLE with `tx_done`=1 and `busy`=0 in that same cycle.
- `tx_start` while `busy`=1 is ignored. Requests are not queued.
- `A` and `parity` are stable from accept until the next accept.
- Reset mid-frame: everything returns to the reset values and the frame is abandoned. INIT restores the line high.

## Timing
- Baud counter:
  - Width is $clog2(`CLKS_PER_BIT`).
  - Cleared on accept; counts 0 to `CLKS_PER_BIT`-1 and wraps.
  - A wrap in START, DATA, PARITY or STOP produces a boundary.
- Pulse spacing: consecutive `end_bit_time` pulses within a frame are exactly `CLKS_PER_BIT` cycles apart.
- Start latency:
  - The first `end_bit_time` (START) occurs in the cycle after the accept edge.
  - The serializer line falls one cycle later.
- Frame length, first START pulse to the `tx_done` cycle: 11×`CLKS_PER_BIT` cycles with parity, 10× without.
- Back-to-back: earliest next accept is the edge ending the `tx_done` cycle.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is used.
  - `parity` output is computed from `par_odd`.
  - Frame is 11 bits.
- Undefined:
  - The PARITY state is never entered; DATA goes to STOP.
  - `parity` is held at 0 and `par_odd` is ignored.
  - Frame is 10 bits.

## Structure
- Package `uart_pkg`:
  - `out_sel` encoding constants `SEL_IDLE`, `SEL_START`, `SEL_DATA`, `SEL_PAR`, `SEL_STOP`.
  - FSM state typedef.
- Sub-module `baud_tick_gen`:
  - Parameter `CLKS_PER_BIT`.
  - Inputs: `clk`, `rst`, `clr`. Output: `tick`.
  - Instantiated once.

## Test plan
- Reset release:
  - Cycle 1 shows `end_bit_time`=1 with `out_sel`=000.
  - Cycle 2 shows `busy`=0.
  - No other pulse while idle.
- `CLKS_PER_BIT`=4, parity enabled, `tx_data`=8'hA5, `par_odd`=0:
  - `counter_i` steps 0 to 7, pulses 4 cycles apart.
  - Serializer line is 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity 0, stop).
  - `tx_done` comes 44 cycles after the START pulse.
- Same byte with `par_odd`=1 → `parity`=1, and the serialized parity bit is 1.
- `tx_start` held high during a frame → exactly one frame. A second frame is accepted only on the edge ending the `tx_done` cycle.
- `rst` asserted during DATA bit 3 → all outputs at reset values, then an INIT pulse, then idle. No `tx_done`.
- `UART_TX_PARITY_EN` undefined, `tx_data`=8'h00 → `out_sel` sequence 001, 010×8, 100, 000; frame is 40 cycles; `parity`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit sequencer: serializer field
// select encoding, FSM state type and the frame parity helper.
package uart_pkg;

  localparam logic [2:0] SEL_IDLE  = 3'b000;
  localparam logic [2:0] SEL_START = 3'b001;
  localparam logic [2:0] SEL_DATA  = 3'b010;
  localparam logic [2:0] SEL_PAR   = 3'b011;
  localparam logic [2:0] SEL_STOP  = 3'b100;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Even parity of the byte, inverted when odd parity is selected.
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle.
// clr restarts the period so the first bit of a frame is full length.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer driving the bit serializer controls.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       par_odd,
  output logic [7:0] A,
  output logic [2:0] out_sel,
  output logic [2:0] counter_i,
  output logic       end_bit_time,
  output logic       parity,
  output logic       busy,
  output logic       tx_done
);

  state_t     state, state_d;
  logic [7:0] a_d;
  logic [2:0] sel_d, cnt_d;
  logic       par_d, ebt_d, busy_d, done_d;
  logic       clr, tick, next_par;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

`ifdef UART_TX_PARITY_EN
  assign next_par = frame_parity(tx_data, par_odd);
`else
  logic unused_par_odd;
  assign unused_par_odd = par_odd;
  assign next_par       = 1'b0;
`endif

  // busy is the registered handshake, so accept is gated on it rather than
  // on the state alone (IDLE's first cycle after INIT still shows busy=1).
  always_comb begin
    state_d = state;
    a_d     = A;
    par_d   = parity;
    sel_d   = out_sel;
    cnt_d   = counter_i;
    ebt_d   = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    clr     = 1'b0;
    case (state)
      ST_INIT: begin
        state_d = ST_IDLE;
        sel_d   = SEL_IDLE;
        ebt_d   = 1'b1;
        busy_d  = 1'b1;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        sel_d  = SEL_IDLE;
        if (tx_start && !busy) begin
          clr     = 1'b1;
          a_d     = tx_data;
          par_d   = next_par;
          state_d = ST_START;
          sel_d   = SEL_START;
          cnt_d   = 3'd0;
          ebt_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          sel_d   = SEL_DATA;
          cnt_d   = 3'd0;
          ebt_d   = 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          ebt_d = 1'b1;
          if (counter_i == 3'd7) begin
            cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            sel_d   = SEL_PAR;
`else
            state_d = ST_STOP;
            sel_d   = SEL_STOP;
`endif
          end else begin
            cnt_d = counter_i + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          sel_d   = SEL_STOP;
          ebt_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          sel_d   = SEL_IDLE;
          ebt_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_INIT;
      A            <= 8'h00;
      parity       <= 1'b0;
      out_sel      <= SEL_IDLE;
      counter_i    <= 3'd0;
      end_bit_time <= 1'b0;
      busy         <= 1'b1;
      tx_done      <= 1'b0;
    end else begin
      state        <= state_d;
      A            <= a_d;
      parity       <= par_d;
      out_sel      <= sel_d;
      counter_i    <= cnt_d;
      end_bit_time <= ebt_d;
      busy         <= busy_d;
      tx_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected frames,
// a negedge monitor models the serializer line and checks each frame.
module tb_uart_tx_ctrl;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int NB = PEN ? 11 : 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       par_odd = 1'b0;
  logic [7:0] A;
  logic [2:0] out_sel, counter_i;
  logic       end_bit_time, parity, busy, tx_done;

  uart_tx_ctrl #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .par_odd(par_odd), .A(A), .out_sel(out_sel), .counter_i(counter_i),
    .end_bit_time(end_bit_time), .parity(parity), .busy(busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] d;
    logic       odd;
    int         acc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_par(exp_t e);
    return PEN ? ((^e.d) ^ e.odd) : 1'b0;
  endfunction

  // Line value of frame bit i: start, data LSB first, [parity], stop.
  function automatic logic exp_line(exp_t e, int i);
    logic [10:0] fb;
    if (PEN) fb = {1'b1, exp_par(e), e.d, 1'b0};
    else     fb = {2'b11, e.d, 1'b0};
    return fb[i];
  endfunction

  function automatic logic [2:0] exp_sel(int i);
    if (i == 0) return 3'b001;
    if (i <= 8) return 3'b010;
    if (PEN && i == 9) return 3'b011;
    return 3'b100;
  endfunction

  // The serializer this block drives: what the line will carry for the
  // field announced in the current end_bit_time cycle.
  function automatic logic ser_bit();
    case (out_sel)
      3'b001:  return 1'b0;
      3'b010:  return A[counter_i];
      3'b011:  return parity;
      default: return 1'b1;
    endcase
  endfunction

  logic in_frame = 1'b0;
  int   pidx, start_cyc, last_pulse;
  exp_t cur;

  always @(negedge clk) begin
    if (end_bit_time === 1'b1) begin
      if (out_sel == 3'b000 && tx_done !== 1'b1) begin
        // INIT pulse: only legal while busy; abandons any frame in flight
        chk("init_pulse_busy", busy, 1);
        if (in_frame) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          in_frame = 1'b0;
        end
      end else if (out_sel == 3'b001 && !in_frame) begin
        if (exp_q.size() == 0) begin
          chk("start_queued", exp_q.size(), 1);
        end else begin
          cur        = exp_q[0];
          in_frame   = 1'b1;
          pidx       = 0;
          start_cyc  = cyc;
          last_pulse = cyc;
          chk("start_latency", cyc, cur.acc + 1);
          chk("start_line", ser_bit(), exp_line(cur, 0));
          chk("start_busy", busy, 1);
        end
      end else if (in_frame) begin
        pidx++;
        chk("pulse_spacing", cyc - last_pulse, N);
        last_pulse = cyc;
        if (tx_done === 1'b1) begin
          chk("frame_bits", pidx, NB);
          chk("frame_cycles", cyc - start_cyc, NB * N);
          chk("done_sel", out_sel, 3'b000);
          chk("done_busy", busy, 0);
          chk("done_A", A, cur.d);
          chk("done_parity", parity, exp_par(cur));
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          in_frame = 1'b0;
        end else begin
          chk("bit_sel", out_sel, exp_sel(pidx));
          chk("bit_counter", counter_i, (pidx >= 1 && pidx <= 8) ? pidx - 1 : 0);
          chk("bit_line", ser_bit(), exp_line(cur, pidx));
        end
      end else begin
        chk("stray_pulse_in_frame", in_frame, 1);
      end
    end else if (tx_done === 1'b1) begin
      chk("done_with_pulse", end_bit_time, 1);
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", busy, 0);
  endtask

  task automatic send(input logic [7:0] d, input logic odd, input bit keep);
    bit   ok;
    exp_t e;
    wait_idle(ok);
    if (!ok) return;
    tx_data  = d;
    par_odd  = odd;
    tx_start = 1'b1;
    e.d = d; e.odd = odd; e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) tx_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_A", A, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_counter", counter_i, 0);
    chk("rst_ebt", end_bit_time, 0);
    chk("rst_parity", parity, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_busy", busy, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("init_ebt", end_bit_time, 1);
    chk("init_sel", out_sel, 0);
    chk("init_busy", busy, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ebt", end_bit_time, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_quiet", end_bit_time, 0);
    end

    send(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0);

    // tx_start held through a frame: the next accept lands on the tx_done edge
    send(8'h5A, 1'b0, 1'b1);
    send(8'hC3, 1'b1, 1'b0);

    // reset in the middle of data bit 3
    send(8'h3C, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_sel == 3'b010 && counter_i == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_data_bit3", found, 1);
    #1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", tx_done, 0);
    end

    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame) break;
    end
    chk("queue_drained", exp_q.size(), 0);
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
